// File: rtl/seq_det_pkg.sv
// Shared defaults for the match logger slice: timestamp width, counter width
// and event FIFO depth. Blocks take these as parameter defaults so a single
// edit here retunes every instance that does not override them.
package seq_det_pkg;

   localparam int DEF_TS_W  = 16;
   localparam int DEF_CNT_W = 16;
   localparam int DEF_DEPTH = 8;
   localparam int PTR_W     = $clog2(DEF_DEPTH);

endpackage

// File: rtl/ts_fifo.sv
// Show-ahead FIFO for event timestamps; head is valid whenever the FIFO is non-empty.
// Latency: push visible at head one cycle later; pop takes effect on the clock edge.
// Backpressure: push at full is refused unless a pop happens in the same cycle.
module ts_fifo
   import seq_det_pkg::*;
#(
   parameter int W     = DEF_TS_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign valid   = (level != '0);
   assign full    = (level == LVL_FULL);
   // A pop frees the slot the simultaneous push needs, so full+pop+push is legal.
   assign do_pop  = pop & valid;
   assign do_push = push & (~full | do_pop);
   // Head reads as zero when empty so stale storage never leaks out.
   assign head    = valid ? mem[rd_ptr] : '0;

   // Storage array: written on accepted pushes only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally (power-of-two depth); level tracked separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/seq_match_logger.sv
// Counts rising edges of the detector match level and queues a timestamp per event.
// Latency: event timestamp visible on m_ts one cycle after the rise (if FIFO was empty).
// Backpressure: m_ready stalls the head; events arriving at a full FIFO are dropped and counted.
module seq_match_logger
   import seq_det_pkg::*;
#(
   parameter int TS_W  = DEF_TS_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   en,
   input  logic                   det_in,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [TS_W-1:0]        m_ts,
   output logic [CNT_W-1:0]       match_cnt,
   output logic [CNT_W-1:0]       drop_cnt,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] fifo_level
);

   logic [TS_W-1:0] ts;
   logic            det_q;
   logic            rise;
   logic            evt;
   logic            pop;
   logic            fifo_full;
   logic            drop;

   // det_q follows det_in even while disabled, so a level held across en 0->1 is not an event.
   assign rise = det_in & ~det_q;
   assign evt  = rise & en & ~clr;
   assign pop  = m_valid & m_ready & ~clr;
   // A pop in the same cycle makes room, so only full-without-pop loses the entry.
   assign drop = evt & fifo_full & ~pop;

   ts_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (evt),
      .din   (ts),
      .pop   (pop),
      .head  (m_ts),
      .valid (m_valid),
      .full  (fifo_full),
      .level (fifo_level)
   );

   // Free-running timestamp, independent of en; restarts from zero on clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ts <= '0;
      else if (clr) ts <= '0;
      else          ts <= ts + 1'b1;
   end

   // Previous detector level for edge detection, tracked through clr as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) det_q <= 1'b0;
      else        det_q <= det_in;
   end

   // Saturating match/drop counters and the sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else if (clr) begin
         match_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (evt && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
         if (drop && (drop_cnt != '1)) drop_cnt  <= drop_cnt + 1'b1;
         if (drop)                     overflow  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed bench for seq_match_logger: default instance plus a narrow 4-bit instance.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Expected timestamps are counted by hand from the last reset/clear.
module tb_seq_match_logger;

   logic        clk = 1'b0;
   logic        rst_n, clr, en, det_in, m_ready;
   logic        m_valid, overflow;
   logic [15:0] m_ts, match_cnt, drop_cnt;
   logic [3:0]  fifo_level;

   logic        s_clr, s_en, s_det, s_ready;
   logic        s_valid, s_ovf;
   logic [3:0]  s_ts, s_mcnt, s_dcnt, s_level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_match_logger dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .det_in(det_in),
      .m_valid(m_valid), .m_ready(m_ready), .m_ts(m_ts),
      .match_cnt(match_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   seq_match_logger #(.TS_W(4), .CNT_W(4), .DEPTH(8)) dut_s (
      .clk(clk), .rst_n(rst_n), .clr(s_clr), .en(s_en), .det_in(s_det),
      .m_valid(s_valid), .m_ready(s_ready), .m_ts(s_ts),
      .match_cnt(s_mcnt), .drop_cnt(s_dcnt), .overflow(s_ovf),
      .fifo_level(s_level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; en = 1'b0; det_in = 1'b0; m_ready = 1'b0;
      s_clr = 1'b0; s_en = 1'b0; s_det = 1'b0; s_ready = 1'b0;
      #12;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d expected 0", m_valid); end
      checks++; if (m_ts !== 16'd0) begin errors++; $display("FAIL rst_ts: got %0d expected 0", m_ts); end
      checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL rst_match: got %0d expected 0", match_cnt); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0d expected 0", overflow); end
      checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
      tick();
      rst_n = 1'b1;
   endtask

   // det_in 0,1,1,1,0,1 after reset: rises captured at ts=1 and ts=5.
   task automatic test_pattern();
      logic [5:0] pat;
      pat = 6'b101110;
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         det_in = pat[i];
         tick();
         checks++; if (m_valid !== (i >= 1)) begin errors++; $display("FAIL pat_valid_%0d: got %0d expected %0d", i, m_valid, (i >= 1)); end
      end
      checks++; if (match_cnt !== 16'd2) begin errors++; $display("FAIL pat_match: got %0d expected 2", match_cnt); end
      checks++; if (fifo_level !== 4'd2) begin errors++; $display("FAIL pat_level: got %0d expected 2", fifo_level); end
      checks++; if (m_ts !== 16'd1) begin errors++; $display("FAIL pat_head0: got %0d expected 1", m_ts); end
      tick();
      checks++; if (m_ts !== 16'd1 || m_valid !== 1'b1) begin errors++; $display("FAIL pat_hold: got ts %0d valid %0d expected ts 1 valid 1", m_ts, m_valid); end
      m_ready = 1'b1;
      tick();
      checks++; if (m_ts !== 16'd5) begin errors++; $display("FAIL pat_head1: got %0d expected 5", m_ts); end
      tick();
      checks++; if (m_valid !== 1'b0 || m_ts !== 16'd0) begin errors++; $display("FAIL pat_empty: got valid %0d ts %0d expected 0 0", m_valid, m_ts); end
      m_ready = 1'b0; det_in = 1'b0;
      tick();
   endtask

   // Level already high when en rises gives no event; a fresh rise gives exactly one.
   task automatic test_en_gate();
      do_clr();
      en = 1'b0; det_in = 1'b1;
      tick();
      en = 1'b1;
      tick(); tick();
      checks++; if (match_cnt !== 16'd0 || fifo_level !== 4'd0) begin errors++; $display("FAIL en_held: got match %0d level %0d expected 0 0", match_cnt, fifo_level); end
      det_in = 1'b0;
      tick();
      det_in = 1'b1;
      tick();
      checks++; if (match_cnt !== 16'd1) begin errors++; $display("FAIL en_rise_match: got %0d expected 1", match_cnt); end
      checks++; if (m_ts !== 16'd4 || fifo_level !== 4'd1) begin errors++; $display("FAIL en_rise_ts: got ts %0d level %0d expected 4 1", m_ts, fifo_level); end
      det_in = 1'b0;
      tick();
   endtask

   // Ten rises into an 8-deep FIFO, then push+pop at full, then drain in order.
   task automatic test_overflow();
      logic [15:0] expv;
      do_clr();
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         det_in = 1'b1; tick();
         det_in = 1'b0; tick();
      end
      checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
      checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d expected 1", overflow); end
      checks++; if (match_cnt !== 16'd10) begin errors++; $display("FAIL ovf_match: got %0d expected 10", match_cnt); end
      checks++; if (m_ts !== 16'd0) begin errors++; $display("FAIL ovf_head: got %0d expected 0", m_ts); end
      det_in = 1'b1; m_ready = 1'b1;
      tick();
      checks++; if (fifo_level !== 4'd8 || drop_cnt !== 16'd2) begin errors++; $display("FAIL full_pp: got level %0d drop %0d expected 8 2", fifo_level, drop_cnt); end
      checks++; if (match_cnt !== 16'd11 || m_ts !== 16'd2) begin errors++; $display("FAIL full_pp_head: got match %0d ts %0d expected 11 2", match_cnt, m_ts); end
      det_in = 1'b0; m_ready = 1'b0;
      tick();
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expv = (k < 7) ? 16'(2 * (k + 1)) : 16'd20;
         checks++; if (m_valid !== 1'b1 || m_ts !== expv) begin errors++; $display("FAIL drain_%0d: got valid %0d ts %0d expected 1 %0d", k, m_valid, m_ts, expv); end
         tick();
      end
      checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL drain_end: got valid %0d level %0d expected 0 0", m_valid, fifo_level); end
      m_ready = 1'b0;
   endtask

   // Asynchronous reset with an entry queued and flags set empties everything at once.
   task automatic test_reset_mid();
      det_in = 1'b1;
      tick();
      checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL rmid_pre: got %0d expected 1", fifo_level); end
      det_in = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0) begin errors++; $display("FAIL rmid_fifo: got valid %0d level %0d expected 0 0", m_valid, fifo_level); end
      checks++; if (match_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_cnt: got match %0d drop %0d ovf %0d expected 0 0 0", match_cnt, drop_cnt, overflow); end
      tick();
      rst_n = 1'b1;
   endtask

   // clr with the FIFO full, overflow set and det_in held high.
   task automatic test_clr();
      do_clr();
      en = 1'b1; m_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         det_in = 1'b1; tick();
         det_in = 1'b0; tick();
      end
      det_in = 1'b1;
      tick();
      checks++; if (overflow !== 1'b1 || fifo_level !== 4'd8) begin errors++; $display("FAIL clr_pre: got ovf %0d level %0d expected 1 8", overflow, fifo_level); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (match_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL clr_cnt: got match %0d drop %0d ovf %0d expected 0 0 0", match_cnt, drop_cnt, overflow); end
      checks++; if (m_valid !== 1'b0 || fifo_level !== 4'd0 || m_ts !== 16'd0) begin errors++; $display("FAIL clr_fifo: got valid %0d level %0d ts %0d expected 0 0 0", m_valid, fifo_level, m_ts); end
      tick(); tick();
      checks++; if (match_cnt !== 16'd0) begin errors++; $display("FAIL clr_held: got %0d expected 0", match_cnt); end
      det_in = 1'b0;
      tick();
      det_in = 1'b1;
      tick();
      checks++; if (match_cnt !== 16'd1 || m_ts !== 16'd3) begin errors++; $display("FAIL clr_ts: got match %0d ts %0d expected 1 3", match_cnt, m_ts); end
      det_in = 1'b0;
      tick();
      clr = 1'b1; det_in = 1'b1;
      tick();
      clr = 1'b0;
      tick();
      checks++; if (match_cnt !== 16'd0 || fifo_level !== 4'd0) begin errors++; $display("FAIL clr_rise: got match %0d level %0d expected 0 0", match_cnt, fifo_level); end
      det_in = 1'b0;
      tick();
   endtask

   // Narrow instance: 4-bit counter saturates at 15, 4-bit timestamps wrap.
   task automatic test_saturate();
      logic [3:0] exp_ts;
      logic [3:0] exp_cnt;
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0; s_en = 1'b1; s_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         exp_ts  = 4'(2 * i);
         exp_cnt = (i >= 14) ? 4'd15 : 4'(i + 1);
         s_det = 1'b1;
         tick();
         checks++; if (s_valid !== 1'b1 || s_ts !== exp_ts) begin errors++; $display("FAIL sat_ts_%0d: got valid %0d ts %0d expected 1 %0d", i, s_valid, s_ts, exp_ts); end
         checks++; if (s_mcnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, s_mcnt, exp_cnt); end
         s_det = 1'b0;
         tick();
      end
      checks++; if (s_level !== 4'd0 || s_dcnt !== 4'd0 || s_ovf !== 1'b0) begin errors++; $display("FAIL sat_end: got level %0d drop %0d ovf %0d expected 0 0 0", s_level, s_dcnt, s_ovf); end
      s_det = 1'b1;
      tick();
      checks++; if (s_mcnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", s_mcnt); end
      s_det = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_pattern();
      test_en_gate();
      test_overflow();
      test_reset_mid();
      test_clr();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
